// File: rtl/seg7_scan_if.sv
// Scanned 7-segment display bus as seen by the receive-side decoder.
// The master drives the active-low segment and digit-select lines.
// The slave returns the recovered digit values and frame status.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg;
  logic [DIGITS-1:0]   sel;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   err;
  logic                frame_valid;

  modport master (
    output seg, sel,
    input  value, blank, err, frame_valid
  );

  modport slave (
    input  seg, sel,
    output value, blank, err, frame_valid
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive side of the DE0 7-segment hex encoding.
// The block taps a multiplexed, active-low display bus and recovers the hex
// nibble of every digit. Bus inputs are double-synchronised because the bus
// may come from another board. A digit is captured once, after its
// {seg,sel} pattern has stayed unchanged for STABLE cycles. frame_valid
// pulses when every digit has been captured at least once since the
// previous pulse.
module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  seg7_scan_if.slave bus
);

  localparam int CW = $clog2(STABLE + 1);

  // Decode result packing: {err, blank, nibble}
  function automatic logic [5:0] decode_seg(input logic [6:0] pattern);
    logic [5:0] res;
    case (pattern)
      7'b1000000: res = {2'b00, 4'h0};
      7'b1111001: res = {2'b00, 4'h1};
      7'b0100100: res = {2'b00, 4'h2};
      7'b0110000: res = {2'b00, 4'h3};
      7'b0011001: res = {2'b00, 4'h4};
      7'b0010010: res = {2'b00, 4'h5};
      7'b0000010: res = {2'b00, 4'h6};
      7'b1111000: res = {2'b00, 4'h7};
      7'b0000000: res = {2'b00, 4'h8};
      7'b0010000: res = {2'b00, 4'h9};
      7'b0001000: res = {2'b00, 4'hA};
      7'b0000011: res = {2'b00, 4'hB};
      7'b1000110: res = {2'b00, 4'hC};
      7'b0100001: res = {2'b00, 4'hD};
      7'b0000110: res = {2'b00, 4'hE};
      7'b0001110: res = {2'b00, 4'hF};
      7'b1111111: res = {2'b01, 4'h0};
      default:    res = {2'b10, 4'h0};
    endcase
    return res;
  endfunction

  // Synchroniser stages and the previous-sample copy used for stability
  logic [6:0]          s1_seg_q, s2_seg_q, prev_seg_q;
  logic [DIGITS-1:0]   s1_sel_q, s2_sel_q, prev_sel_q;

  // Stability counter, frame tracking and output registers
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                frame_valid_q, frame_valid_d;

  // Combinational helpers
  logic [DIGITS-1:0]   sel_low_s;
  logic [DIGITS-1:0]   seen_n_s;
  logic                stable_s;
  logic                onehot_s;
  logic                capture_s;
  logic                accept_s;
  logic [5:0]          dec_s;

  // Two-flop synchroniser plus the previous-sample register, all idle-dark at reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_seg_q   <= 7'h7F;
      s1_sel_q   <= {DIGITS{1'b1}};
      s2_seg_q   <= 7'h7F;
      s2_sel_q   <= {DIGITS{1'b1}};
      prev_seg_q <= 7'h7F;
      prev_sel_q <= {DIGITS{1'b1}};
    end else begin
      s1_seg_q   <= bus.seg;
      s1_sel_q   <= bus.sel;
      s2_seg_q   <= s1_seg_q;
      s2_sel_q   <= s1_sel_q;
      prev_seg_q <= s2_seg_q;
      prev_sel_q <= s2_sel_q;
    end
  end

  // Detect a stable, single-digit sample and fire the one-shot capture
  always_comb begin
    sel_low_s = ~s2_sel_q;
    stable_s  = (s2_seg_q == prev_seg_q) && (s2_sel_q == prev_sel_q);
    // Exactly one select low: non-zero and clearing the lowest set bit leaves zero
    onehot_s  = (sel_low_s != {DIGITS{1'b0}}) &&
                ((sel_low_s & (sel_low_s - DIGITS'(1))) == {DIGITS{1'b0}});
    // cnt reaches STABLE-1 exactly once per stable period, then saturates past it
    capture_s = stable_s && (cnt_q == CW'(STABLE - 1));
    accept_s  = capture_s && onehot_s;
    dec_s     = decode_seg(s2_seg_q);
  end

  // Next-state for the stability counter, saturating at STABLE
  always_comb begin
    cnt_d = cnt_q;
    if (!stable_s) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q != CW'(STABLE)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next-state for digit outputs and frame tracking on an accepted capture
  always_comb begin
    value_d       = value_q;
    blank_d       = blank_q;
    err_d         = err_q;
    seen_d        = seen_q;
    frame_valid_d = 1'b0;
    seen_n_s      = seen_q | sel_low_s;
    if (accept_s) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (sel_low_s[k]) begin
          value_d[4*k +: 4] = dec_s[3:0];
          blank_d[k]        = dec_s[4];
          err_d[k]          = dec_s[5];
        end else begin
          value_d[4*k +: 4] = value_q[4*k +: 4];
          blank_d[k]        = blank_q[k];
          err_d[k]          = err_q[k];
        end
      end
      // Repeat captures of one digit leave seen unchanged, so they never close a frame
      if (seen_n_s == {DIGITS{1'b1}}) begin
        frame_valid_d = 1'b1;
        seen_d        = {DIGITS{1'b0}};
      end else begin
        frame_valid_d = 1'b0;
        seen_d        = seen_n_s;
      end
    end else begin
      frame_valid_d = 1'b0;
      seen_d        = seen_q;
    end
  end

  // State and registered outputs; reset clears any partially collected frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= {CW{1'b0}};
      seen_q        <= {DIGITS{1'b0}};
      value_q       <= {(4*DIGITS){1'b0}};
      blank_q       <= {DIGITS{1'b1}};
      err_q         <= {DIGITS{1'b0}};
      frame_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      value_q       <= value_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.blank       = blank_q;
  assign bus.err         = err_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE=8).
// Each hold() call predicts the capture it should cause and queues the
// expected output state for the predicted edge. A negedge monitor pops
// those entries and compares every output on every cycle.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int unsigned edge_n;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        fv;
  } ev_t;

  ev_t sb[$];

  int          checks   = 0;
  int          errors   = 0;
  int unsigned edge_cnt = 0;

  logic [6:0] pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Future-state model, advanced when stimulus is driven
  logic [15:0] m_value;
  logic [3:0]  m_blank, m_err, m_seen;

  // Expected output state as of the current edge
  logic [15:0] c_value = 16'h0000;
  logic [3:0]  c_blank = 4'hF;
  logic [3:0]  c_err   = 4'h0;
  logic        c_fv    = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, got, exp, edge_cnt);
    end
  endtask

  // Monitor: apply scoreboard entries due at this edge, then compare all outputs
  always @(negedge clk) begin
    ev_t ev;
    c_fv = 1'b0;
    if (!reset_n) begin
      c_value = 16'h0000;
      c_blank = 4'hF;
      c_err   = 4'h0;
      sb.delete();
    end else begin
      while (sb.size() != 0 && sb[0].edge_n == edge_cnt) begin
        ev = sb.pop_front();
        c_value = ev.value;
        c_blank = ev.blank;
        c_err   = ev.err;
        c_fv    = ev.fv;
      end
    end
    check("value",       bus.value,                 c_value);
    check("blank",       {12'h000, bus.blank},      {12'h000, c_blank});
    check("err",         {12'h000, bus.err},        {12'h000, c_err});
    check("frame_valid", {15'h0000, bus.frame_valid}, {15'h0000, c_fv});
  end

  task automatic model_reset();
    m_value = 16'h0000;
    m_blank = 4'hF;
    m_err   = 4'h0;
    m_seen  = 4'h0;
  endtask

  // Drive {seg,sel} for n cycles, queueing the expected capture if one is due
  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    ev_t        ev;
    logic [3:0] low;
    int         nib;
    logic       found;
    bus.seg = s;
    bus.sel = d;
    low = ~d;
    if (n >= STABLE + 1 && $countones(low) == 1) begin
      found = 1'b0;
      nib   = 0;
      for (int i = 0; i < 16; i++) begin
        if (pat[i] == s) begin
          found = 1'b1;
          nib   = i;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (low[k]) begin
          m_value[4*k +: 4] = found ? nib[3:0] : 4'h0;
          m_blank[k]        = (s == 7'h7F);
          m_err[k]          = !found && (s != 7'h7F);
        end
      end
      m_seen = m_seen | low;
      ev.fv  = (m_seen == 4'hF);
      if (ev.fv) m_seen = 4'h0;
      ev.edge_n = edge_cnt + 1 + STABLE + 2;
      ev.value  = m_value;
      ev.blank  = m_blank;
      ev.err    = m_err;
      sb.push_back(ev);
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan_1234();
    for (int d = 0; d < 4; d++) begin
      hold(pat[d + 1], ~(4'b0001 << d), 12);
    end
  endtask

  initial begin
    // 1: reset, then idle bus for 50 cycles
    bus.seg = 7'h7F;
    bus.sel = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(7'h7F, 4'hF, 50);

    // 2: digit 0 shows 3, captured exactly once
    hold(7'b0110000, 4'b1110, 20);

    // 3: too-short glitch on digit 1 never captures
    hold(7'b1111001, 4'b1101, 7);
    hold(7'h7F, 4'hF, 12);

    // 4: two full scans of 1,2,3,4, one frame pulse each
    scan_1234();
    scan_1234();
    hold(7'h7F, 4'hF, 12);

    // 5: illegal pattern, then dark, then ghosted select
    hold(7'b0111111, 4'b1011, 12);
    hold(7'h7F, 4'b1011, 12);
    hold(7'b0000000, 4'b1100, 20);
    hold(7'h7F, 4'hF, 12);

    // 6: partial frame, reset pulse, then digit 3 alone
    hold(pat[5], 4'b1110, 12);
    hold(pat[6], 4'b1101, 12);
    hold(pat[7], 4'b1011, 12);
    hold(7'h7F, 4'hF, 12);
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(7'h7F, 4'hF, 12);
    hold(pat[8], 4'b0111, 12);
    hold(7'h7F, 4'hF, 20);

    // Frame after reset completes once digits 0..2 join digit 3
    hold(pat[10], 4'b1110, 12);
    hold(pat[11], 4'b1101, 12);
    hold(pat[12], 4'b1011, 12);
    hold(7'h7F, 4'hF, 20);

    check("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
